uib_arbiter: RTL
================

# uib_arbiter

Round-robin arbiter that shares one uib master port between `NMASTER` requesting masters, such as the cpu and a future DMA engine. It sits between the masters and the uib master slot, and looks to the bus like a single standard master. It holds a grant for a whole transaction, forwards `ready` and read data only to the owner, and frees the bus itself when a slave fails to answer within `TIMEOUT` cycles.

## Interface
- `NMASTER`, default 2: number of upstream masters (2..8).
- `XLEN`, default 32: data width.
- `AW`, default 28: in-slave address width (`XLEN - SLAVE_WIDTH`).
- `NW`, default 4: slave-number width (`SLAVE_WIDTH`).
- `TIMEOUT`, default 255: maximum cycles to wait for `ready` (1..65535).
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `up_req  in  [NMASTER-1:0]`: per-master request, held high until `ready`.
- `up_wen  in  [NMASTER-1:0]`: per-master write enable.
- `up_addr  in  [NMASTER-1:0][AW-1:0]`: per-master in-slave address.
- `up_num  in  [NMASTER-1:0][NW-1:0]`: per-master target slave number.
- `up_mode  in  [NMASTER-1:0][2:0]`: per-master access size/sign mode, passed through.
- `up_dat_o  in  [NMASTER-1:0][XLEN-1:0]`: per-master write data.
- `up_dat_i  out  XLEN`: read data, broadcast to all masters.
- `up_ready  out  [NMASTER-1:0]`: per-master completion pulse.
- `dn_req, dn_wen  out  1`: request and write enable to the uib master slot.
- `dn_addr  out  AW`, `dn_num  out  NW`, `dn_mode  out  3`, `dn_dat_o  out  XLEN`: to the uib master slot.
- `dn_dat_i  in  XLEN`: read data from the uib.
- `dn_ready  in  1`: completion from the uib.
- `grant  out  [NMASTER-1:0]`: one-hot owner; zero when idle.
- `busy  out  1`: high in the BUSY state.
- `tmo_err  out  1`: sticky; set on any timeout, cleared only by `rst`.

## Operation
- FSM states: IDLE, BUSY.
- Registers: `grant`, round-robin pointer `ptr` (`$clog2(NMASTER)` bits), timeout counter `cnt` (`$clog2(TIMEOUT+1)` bits), `tmo_err`.

IDLE:
- If `up_req` is non-zero, select the first set bit scanning from index `ptr` upward, wrapping `NMASTER-1` to 0.
- Register that bit in `grant`, clear `cnt`, go to BUSY.
- Otherwise stay in IDLE with `grant` = 0.

BUSY, with owner g:
- Downstream mux, all combinational from `grant`:
  - `dn_req` = `up_req[g]`.
  - `dn_wen`, `dn_addr`, `dn_num`, `dn_mode`, `dn_dat_o` = master g's signals.
- `up_ready[g]` = `dn_ready`; all other `up_ready` bits stay 0.
- Normal completion: `dn_ready`=1. Go to IDLE, set `ptr` = (g+1) mod `NMASTER`, clear `grant`.
- Abort: `up_req[g]`=0 with `dn_ready`=0. Go to IDLE and clear `grant`. `ptr` is unchanged, so the aborting master keeps its priority.
- Timeout: `cnt` reaches `TIMEOUT-1` with `dn_ready` still 0.
  - Drive `up_ready[g]`=1 that cycle with `up_dat_i` forced to 0.
  - Set `tmo_err`.
  - Update `ptr` as for normal completion, go to IDLE.
- Otherwise `cnt` increments.
- Simultaneous `dn_ready` and timeout terminal count: the real `dn_ready` and `dn_dat_i` win, and `tmo_err` is not set.

Outside BUSY:
- All `dn_*` outputs are 0.
- All `up_ready` bits are 0.
- `up_dat_i` = `dn_dat_i`, except during the timeout cycle.

Fixed rules:
- Requests that appear or drop while another master owns the bus never change `grant`.
- `grant` is always one-hot or zero.

## Timing
- Reset values:
  - state IDLE; `grant`=0, `ptr`=0, `cnt`=0, `tmo_err`=0, `busy`=0.
  - All `dn_*` outputs 0; `up_ready`=0.
- Reset asserted mid-BUSY returns to IDLE on the next edge with no `up_ready` pulse; the downstream request is dropped.
- Arbitration latency: a request sampled in IDLE at edge N appears on `dn_req` after edge N (one cycle).
- `dn_ready` to `up_ready[g]` is combinational (zero cycles); read data is valid in the same cycle.
- Back-to-back: after `ready` at cycle N, the FSM is IDLE in cycle N+1 and the next grant is visible in cycle N+2.
  - Minimum overhead is 1 idle cycle per transaction.
- Timeout pulse: with `dn_ready` held low, `up_ready` fires in the `TIMEOUT`-th BUSY cycle (first BUSY cycle counts as 1).

## Test plan
- Single read: master 0 reads, slave answers `dn_ready` 3 cycles into BUSY with `0x12345678` -> `up_ready[0]` pulses with `up_dat_i`=`0x12345678`; `up_ready[1]`=0; `grant` goes 01 -> 00.
- Contention, `NMASTER`=2: both `up_req` held high, slave always answers in 1 cycle -> `grant` sequence 01, 10, 01, 10, with one idle cycle between grants.
- Wrap, `NMASTER`=3: `ptr`=2, requests on masters 0 and 1 -> master 0 is granted first, then master 1.
- Timeout, `TIMEOUT`=4: `dn_ready` never asserted -> `up_ready[g]` in the 4th BUSY cycle with `up_dat_i`=0; `tmo_err`=1 and stays 1; the next requester is granted afterwards.
- Abort: owner drops `up_req` in its 2nd BUSY cycle -> `dn_req`=0 that cycle; IDLE next cycle; `ptr` unchanged.
- Reset mid-BUSY: `rst` pulsed for 1 cycle -> `grant`=0, `busy`=0, `tmo_err`=0, no `up_ready` pulse; arbitration restarts from master 0.

Source files
------------

// File: rtl/uib_arbiter.sv
// Round-robin arbiter sharing one uib master slot between NMASTER upstream masters.
// A grant is held for a whole transaction; a stalled slave is released after TIMEOUT cycles.
module uib_arbiter #(
    parameter int NMASTER = 2,
    parameter int XLEN    = 32,
    parameter int AW      = 28,
    parameter int NW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NMASTER-1:0]             up_req,
    input  logic [NMASTER-1:0]             up_wen,
    input  logic [NMASTER-1:0][AW-1:0]     up_addr,
    input  logic [NMASTER-1:0][NW-1:0]     up_num,
    input  logic [NMASTER-1:0][2:0]        up_mode,
    input  logic [NMASTER-1:0][XLEN-1:0]   up_dat_o,
    output logic [XLEN-1:0]                up_dat_i,
    output logic [NMASTER-1:0]             up_ready,
    output logic                           dn_req,
    output logic                           dn_wen,
    output logic [AW-1:0]                  dn_addr,
    output logic [NW-1:0]                  dn_num,
    output logic [2:0]                     dn_mode,
    output logic [XLEN-1:0]                dn_dat_o,
    input  logic [XLEN-1:0]                dn_dat_i,
    input  logic                           dn_ready,
    output logic [NMASTER-1:0]             grant,
    output logic                           busy,
    output logic                           tmo_err
);

    localparam int PW = $clog2(NMASTER);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NMASTER - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [CW-1:0]       cnt;

    logic [NMASTER-1:0]  sel_grant;
    logic                sel_found;
    logic [PW-1:0]       own;
    logic                own_req;
    logic [PW-1:0]       ptr_next;
    logic                tmo_fire;

    // Round-robin pick: first requester at or above ptr, wrapping to 0.
    always_comb begin
        sel_grant = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NMASTER; k++) begin
            for (int i = 0; i < NMASTER; i++) begin
                if ((i == ((int'(ptr) + k) % NMASTER)) && !sel_found && up_req[i]) begin
                    sel_found    = 1'b1;
                    sel_grant[i] = 1'b1;
                end else begin
                    sel_found = sel_found;
                end
            end
        end
    end

    // Decode the current owner index and its live request.
    always_comb begin
        own     = '0;
        own_req = 1'b0;
        for (int i = 0; i < NMASTER; i++) begin
            if (grant[i]) begin
                own     = PW'(i);
                own_req = up_req[i];
            end else begin
                own     = own;
            end
        end
        if (own == PTR_LAST) begin
            ptr_next = '0;
        end else begin
            ptr_next = own + PW'(1);
        end
    end

    // A real dn_ready or an abort both take precedence over the terminal count.
    assign tmo_fire = (state == BUSY) && own_req && !dn_ready && (cnt == CNT_LAST);

    // Downstream mux and upstream completion routing, driven only while BUSY.
    always_comb begin
        dn_req   = 1'b0;
        dn_wen   = 1'b0;
        dn_addr  = '0;
        dn_num   = '0;
        dn_mode  = 3'b000;
        dn_dat_o = '0;
        for (int i = 0; i < NMASTER; i++) begin
            if ((state == BUSY) && grant[i]) begin
                dn_req   = up_req[i];
                dn_wen   = up_wen[i];
                dn_addr  = up_addr[i];
                dn_num   = up_num[i];
                dn_mode  = up_mode[i];
                dn_dat_o = up_dat_o[i];
            end else begin
                dn_req = dn_req;
            end
        end
        if ((state == BUSY) && (dn_ready || tmo_fire)) begin
            up_ready = grant;
        end else begin
            up_ready = '0;
        end
        if (tmo_fire) begin
            up_dat_i = '0;
        end else begin
            up_dat_i = dn_dat_i;
        end
    end

    assign busy = (state == BUSY);

    // Arbitration FSM: grant, round-robin pointer, timeout counter, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            tmo_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|up_req) begin
                        grant <= sel_grant;
                        cnt   <= '0;
                        state <= BUSY;
                    end else begin
                        grant <= '0;
                    end
                end
                BUSY: begin
                    if (dn_ready) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= ptr_next;
                    end else if (!own_req) begin
                        // Abort keeps ptr so the aborting master retains priority.
                        state <= IDLE;
                        grant <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        grant   <= '0;
                        ptr     <= ptr_next;
                        tmo_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
